skeleton_line_drawer: RTL and testbench

Consumes the decoded pose packet produced by the SPI receive stage and rasterizes the skeleton polyline P1→P2→P3→P4 into pixel-write requests for the framebuffer write port. It runs in the `clk` domain, snapshots the coordinates once per received packet, and draws three Bresenham segments, one pixel per accepted write. The color is the packet's 12-bit RGB value.

---
 rtl/skeleton_line_drawer.sv | 198 +++++++++++++++++++
 tb/tb_skeleton_line_drawer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/skeleton_line_drawer.sv
// Rasterizes the pose polyline P1->P2->P3->P4 into framebuffer pixel writes (Bresenham).
// One pixel per accepted write; fb_we/fb_x/fb_y/fb_color hold while fb_ready is low.
module skeleton_line_drawer #(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        done,
  input  logic [9:0]  x_1,
  input  logic [9:0]  y_1,
  input  logic [9:0]  x_2,
  input  logic [9:0]  y_2,
  input  logic [9:0]  x_3,
  input  logic [9:0]  y_3,
  input  logic [9:0]  x_4,
  input  logic [9:0]  y_4,
  input  logic [3:0]  r,
  input  logic [3:0]  g,
  input  logic [3:0]  b,
  input  logic        fb_ready,
  output logic        fb_we,
  output logic [9:0]  fb_x,
  output logic [9:0]  fb_y,
  output logic [11:0] fb_color,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [9:0] X_MAX = 10'(H_RES - 1);
  localparam logic [9:0] Y_MAX = 10'(V_RES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SEG_INIT,
    DRAW,
    SEG_NEXT,
    FINISH
  } state_t;

  state_t state, state_nxt;

  // [0],[1] are the synchronizer, [2] remembers the previous synchronized level
  logic [2:0]  sync_q;
  logic        done_edge;
  logic        pending;
  logic        start;

  logic [9:0]  vx [4];
  logic [9:0]  vy [4];
  logic [9:0]  in_x [4];
  logic [9:0]  in_y [4];
  logic [11:0] color_q;
  logic [1:0]  seg_idx;

  logic [9:0]  cur_x, cur_y, end_x, end_y;
  logic signed [11:0] dx, dy, err;
  logic        x_neg, y_neg;

  logic [9:0]  seg_x0, seg_y0, seg_x1, seg_y1;
  logic signed [11:0] diff_x, diff_y, abs_x, abs_y;
  logic signed [11:0] e2, err_step;
  logic        step_x, step_y, at_end;

  function automatic logic [9:0] clamp(input logic [9:0] v, input logic [9:0] m);
    return (v > m) ? m : v;
  endfunction

  assign in_x[0] = x_1;
  assign in_x[1] = x_2;
  assign in_x[2] = x_3;
  assign in_x[3] = x_4;
  assign in_y[0] = y_1;
  assign in_y[1] = y_2;
  assign in_y[2] = y_3;
  assign in_y[3] = y_4;

  assign done_edge = sync_q[1] & ~sync_q[2];
  assign start     = done_edge | pending;

  assign seg_x0 = vx[seg_idx];
  assign seg_y0 = vy[seg_idx];
  assign seg_x1 = vx[seg_idx + 2'd1];
  assign seg_y1 = vy[seg_idx + 2'd1];

  always_comb begin
    diff_x = $signed({2'b00, seg_x1}) - $signed({2'b00, seg_x0});
    diff_y = $signed({2'b00, seg_y1}) - $signed({2'b00, seg_y0});
    abs_x  = (diff_x < 0) ? -diff_x : diff_x;
    abs_y  = (diff_y < 0) ? -diff_y : diff_y;
  end

  // Both Bresenham decisions are taken from the pre-step error
  always_comb begin
    e2       = {err[10:0], 1'b0};
    step_x   = (e2 >= dy);
    step_y   = (e2 <= dx);
    err_step = err;
    if (step_x) err_step = err_step + dy;
    if (step_y) err_step = err_step + dx;
  end

  assign at_end = (cur_x == end_x) && (cur_y == end_y);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = SEG_INIT;
      SEG_INIT: state_nxt = DRAW;
      DRAW:     if (fb_ready && at_end) state_nxt = SEG_NEXT;
      SEG_NEXT: state_nxt = (seg_idx == 2'd2) ? FINISH : SEG_INIT;
      FINISH:   state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= '0;
      pending    <= 1'b0;
      color_q    <= '0;
      seg_idx    <= '0;
      cur_x      <= '0;
      cur_y      <= '0;
      end_x      <= '0;
      end_y      <= '0;
      dx         <= '0;
      dy         <= '0;
      err        <= '0;
      x_neg      <= 1'b0;
      y_neg      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        vx[i] <= '0;
        vy[i] <= '0;
      end
    end else begin
      sync_q     <= {sync_q[1:0], done};
      frame_done <= 1'b0;

      // Packets arriving mid-frame collapse into one queued restart
      if (done_edge && state != IDLE) pending <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < 4; i++) begin
              vx[i] <= clamp(in_x[i], X_MAX);
              vy[i] <= clamp(in_y[i], Y_MAX);
            end
            color_q <= {r, g, b};
            seg_idx <= '0;
            busy    <= 1'b1;
            pending <= 1'b0;
          end
        end
        SEG_INIT: begin
          cur_x <= seg_x0;
          cur_y <= seg_y0;
          end_x <= seg_x1;
          end_y <= seg_y1;
          dx    <= abs_x;
          dy    <= -abs_y;
          err   <= abs_x - abs_y;
          x_neg <= (seg_x1 < seg_x0);
          y_neg <= (seg_y1 < seg_y0);
        end
        DRAW: begin
          if (fb_ready && !at_end) begin
            err <= err_step;
            if (step_x) cur_x <= x_neg ? cur_x - 10'd1 : cur_x + 10'd1;
            if (step_y) cur_y <= y_neg ? cur_y - 10'd1 : cur_y + 10'd1;
          end
        end
        SEG_NEXT: begin
          if (seg_idx != 2'd2) seg_idx <= seg_idx + 2'd1;
        end
        FINISH: begin
          frame_done <= 1'b1;
          busy       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign fb_we    = (state == DRAW);
  assign fb_x     = cur_x;
  assign fb_y     = cur_y;
  assign fb_color = color_q;

endmodule

// File: tb/tb_skeleton_line_drawer.sv
// Directed bench for skeleton_line_drawer: captures accepted writes and checks them against hand-computed pixel lists.
module tb_skeleton_line_drawer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        done = 1'b0;
  logic [9:0]  x_1 = '0, y_1 = '0, x_2 = '0, y_2 = '0;
  logic [9:0]  x_3 = '0, y_3 = '0, x_4 = '0, y_4 = '0;
  logic [3:0]  r = '0, g = '0, b = '0;
  logic        fb_ready = 1'b1;
  logic        fb_we;
  logic [9:0]  fb_x, fb_y;
  logic [11:0] fb_color;
  logic        busy, frame_done;

  int tests = 0;
  int fails = 0;
  int fd_cnt = 0;

  logic [9:0]  qx [$];
  logic [9:0]  qy [$];
  logic [11:0] qc [$];

  logic        bp_en = 1'b0;
  logic [15:0] bp_pat = 16'b1001_1001_1100_1001;
  int          bp_idx = 0;

  logic        stall_prev = 1'b0;
  logic [9:0]  px, py;
  logic [11:0] pc;

  skeleton_line_drawer #(.H_RES(640), .V_RES(480)) dut (
    .clk(clk), .reset_n(reset_n), .done(done),
    .x_1(x_1), .y_1(y_1), .x_2(x_2), .y_2(y_2),
    .x_3(x_3), .y_3(y_3), .x_4(x_4), .y_4(y_4),
    .r(r), .g(g), .b(b),
    .fb_ready(fb_ready), .fb_we(fb_we), .fb_x(fb_x), .fb_y(fb_y),
    .fb_color(fb_color), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (bp_en) begin
      fb_ready = bp_pat[bp_idx % 16];
      bp_idx++;
    end else begin
      fb_ready = 1'b1;
    end
  end

  // Record accepted writes and verify a stalled request is held unchanged
  always @(negedge clk) begin
    if (reset_n) begin
      if (stall_prev)
        check("stall_hold", {fb_we, fb_x, fb_y, fb_color}, {1'b1, px, py, pc});
      if (fb_we && fb_ready) begin
        qx.push_back(fb_x);
        qy.push_back(fb_y);
        qc.push_back(fb_color);
      end
      if (frame_done) fd_cnt++;
      stall_prev = fb_we && !fb_ready;
      px = fb_x;
      py = fb_y;
      pc = fb_color;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic set_pts(input logic [9:0] ax, ay, bx, by, cx, cy, dx, dy);
    x_1 = ax; y_1 = ay; x_2 = bx; y_2 = by;
    x_3 = cx; y_3 = cy; x_4 = dx; y_4 = dy;
  endtask

  task automatic pulse_done();
    @(posedge clk); #1 done = 1'b1;
    repeat (3) @(posedge clk);
    #1 done = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic clear_log();
    qx.delete(); qy.delete(); qc.delete();
    fd_cnt = 0;
  endtask

  task automatic wait_frames(input int n, input string tag);
    int budget;
    budget = 2000;
    while (fd_cnt < n && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    repeat (2) @(posedge clk);
    check(tag, fd_cnt >= n, 1);
  endtask

  task automatic check_px(input string tag, input int idx, input logic [9:0] ex, input logic [9:0] ey);
    if (idx < qx.size()) check(tag, {qx[idx], qy[idx]}, {ex, ey});
    else check(tag, qx.size(), idx + 1);
  endtask

  logic [9:0] steep_x [8] = '{10'd5, 10'd5, 10'd4, 10'd4, 10'd4, 10'd4, 10'd3, 10'd3};
  logic [9:0] steep_y [8] = '{10'd5, 10'd6, 10'd7, 10'd8, 10'd9, 10'd10, 10'd11, 10'd12};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {fb_we, fb_x, fb_y, fb_color, busy, frame_done}, 64'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Horizontal line plus two degenerate segments
    clear_log();
    r = 4'hA; g = 4'h5; b = 4'h3;
    set_pts(10, 20, 15, 20, 15, 20, 15, 20);
    pulse_done();
    wait_frames(1, "horiz_frame");
    check("horiz_count", qx.size(), 8);
    for (int i = 0; i < 6; i++) check_px("horiz_px", i, 10'(10 + i), 10'd20);
    check_px("horiz_p3", 6, 10'd15, 10'd20);
    check_px("horiz_p4", 7, 10'd15, 10'd20);
    if (qc.size() > 0) check("horiz_color", qc[0], 12'hA53);
    check("horiz_fd", fd_cnt, 1);
    check("horiz_idle", busy, 0);

    // Steep negative-X slope
    clear_log();
    set_pts(5, 5, 3, 12, 3, 12, 3, 12);
    pulse_done();
    wait_frames(1, "steep_frame");
    check("steep_count", qx.size(), 10);
    for (int i = 0; i < 8; i++) check_px("steep_px", i, steep_x[i], steep_y[i]);

    // Diagonal under backpressure
    clear_log();
    set_pts(0, 0, 7, 7, 7, 7, 7, 7);
    bp_en = 1'b1;
    pulse_done();
    wait_frames(1, "bp_frame");
    bp_en = 1'b0;
    check("bp_count", qx.size(), 10);
    for (int i = 0; i < 8; i++) check_px("bp_px", i, 10'(i), 10'(i));

    // Coordinate clamp
    clear_log();
    set_pts(1000, 600, 1023, 1023, 639, 479, 639, 479);
    pulse_done();
    wait_frames(1, "clamp_frame");
    check_px("clamp_first", 0, 10'd639, 10'd479);
    check("clamp_count", qx.size(), 3);

    // Two packets during a frame merge into one follow-on frame
    clear_log();
    set_pts(0, 0, 40, 0, 40, 0, 40, 0);
    pulse_done();
    pulse_done();
    set_pts(100, 50, 102, 50, 102, 50, 102, 50);
    pulse_done();
    wait_frames(2, "pend_frames");
    repeat (60) @(posedge clk);
    check("pend_fd", fd_cnt, 2);
    check("pend_count", qx.size(), 48);
    check_px("pend_a_last", 42, 10'd40, 10'd0);
    check_px("pend_b_first", 43, 10'd100, 10'd50);
    check_px("pend_b_last", 47, 10'd102, 10'd50);

    // Asynchronous reset in the middle of a segment
    clear_log();
    set_pts(0, 0, 40, 0, 40, 0, 40, 0);
    pulse_done();
    repeat (5) @(posedge clk);
    check("rst_mid_busy", {busy, fb_we}, 2'b11);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_out", {fb_we, fb_x, fb_y, fb_color, busy, frame_done}, 64'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    clear_log();
    set_pts(7, 3, 9, 3, 9, 3, 9, 3);
    pulse_done();
    wait_frames(1, "rst_frame");
    check("rst_count", qx.size(), 5);
    check_px("rst_first", 0, 10'd7, 10'd3);
    check("rst_fd", fd_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
